alu_mul_seq: RTL and testbench

Multi-cycle multiply sequencer that computes the low 32 bits of a 32x32 product by driving the shared 32-bit ALU through repeated ADD and SLL operations. It sits beside the ALU in the multi-stage processor: while busy it owns the ALU operand and opcode inputs, and the execute stage muxes them in. It has a start/busy/done handshake and issues one ALU operation per cycle.

---
 rtl/alu_mul_seq_if.sv | 24 ++
 rtl/alu_mul_seq.sv | 109 ++++++++++
 tb/tb_alu_mul_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Handshake and ALU-drive bundle between the multiply sequencer and the execute stage.
// The master side requests multiplies and supplies the ALU result; the slave is the sequencer.
interface alu_mul_seq_if;
    logic        start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    modport master (
        output start, src_a, src_b, alu_out,
        input  busy, done, product, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, src_a, src_b, alu_out,
        output busy, done, product, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU, one ADD or SLL per cycle.
// Optional MUL_EARLY_EXIT_EN stops as soon as the remaining multiplier bits are zero.
module alu_mul_seq (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b1000;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    state_t      start_state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] product;
    logic [4:0]  cnt;
    logic        accept;
    logic        last_shift;

    assign accept      = bus.start && (state == IDLE || state == DONE);
    assign bus.product = product;

    // First working state chosen from the incoming multiplier's low bit.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        if (bus.src_b == 32'd0)
            start_state = DONE;
        else if (bus.src_b[0])
            start_state = ADD;
        else
            start_state = SHIFT;
        last_shift = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
        start_state = bus.src_b[0] ? ADD : SHIFT;
        last_shift  = (cnt == 5'd31);
`endif
    end

    always_comb begin
        next_state = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.alu_op = OP_ADD;
        bus.alu_a  = 32'd0;
        bus.alu_b  = 32'd0;
        case (state)
            IDLE: begin
                if (bus.start)
                    next_state = start_state;
            end
            ADD: begin
                bus.busy   = 1'b1;
                bus.alu_a  = acc;
                bus.alu_b  = mcand;
                next_state = SHIFT;
            end
            SHIFT: begin
                bus.busy   = 1'b1;
                bus.alu_op = OP_SLL;
                bus.alu_a  = mcand;
                bus.alu_b  = 32'd1;
                // mplier still holds the pre-shift value, so bit 1 is the next bit to process.
                if (last_shift)
                    next_state = DONE;
                else if (mplier[1])
                    next_state = ADD;
                else
                    next_state = SHIFT;
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = bus.start ? start_state : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            acc     <= 32'd0;
            cnt     <= 5'd0;
            product <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                mcand  <= bus.src_a;
                mplier <= bus.src_b;
                acc    <= 32'd0;
                cnt    <= 5'd0;
            end else if (state == ADD) begin
                acc <= bus.alu_out;
            end else if (state == SHIFT) begin
                mcand  <= bus.alu_out;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
            end
            // A zero multiplier accepted straight into DONE has a fresh accumulator of zero.
            if (next_state == DONE)
                product <= accept ? 32'd0 : acc;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed and random multiplies against an arithmetic model.
// Follows MUL_EARLY_EXIT_EN to pick the expected iteration count.
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] last_product = 32'd0;

    always #5 clk = ~clk;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behaviour of the shared ALU for the two opcodes the sequencer uses.
    assign bus.alu_out = (bus.alu_op == 4'b1000) ? (bus.alu_a << bus.alu_b[4:0]) :
                         (bus.alu_op == 4'b0000) ? (bus.alu_a + bus.alu_b) : 32'd0;

    function automatic int exp_iters(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 31; i >= 0; i--)
            if (b[i]) return i + 1;
        return 0;
`else
        return 32;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one multiply from a negedge and follows it to the done pulse.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input bit noisy,
                                  input bit chain, input logic [31:0] na, input logic [31:0] nb);
        logic [67:0] expq[$];
        logic [31:0] acc_m;
        logic [31:0] prod_m;
        int s;
        int p;
        int busy_cnt;
        int idx;
        int done_at;
        bit trace_ok;
        bit held_ok;

        s      = exp_iters(b);
        p      = $countones(b);
        prod_m = a * b;
        acc_m  = 32'd0;
        for (int i = 0; i < s; i++) begin
            if (b[i]) begin
                expq.push_back({4'b0000, acc_m, a << i});
                acc_m = acc_m + (a << i);
            end
            expq.push_back({4'b1000, a << i, 32'd1});
        end

        bus.start = 1'b1;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        done_at  = 0;
        busy_cnt = 0;
        idx      = 0;
        trace_ok = 1'b1;
        held_ok  = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_at = k;
                break;
            end
            if (bus.busy) begin
                busy_cnt++;
                if (idx >= expq.size() || {bus.alu_op, bus.alu_a, bus.alu_b} !== expq[idx])
                    trace_ok = 1'b0;
                idx++;
                if (bus.product !== last_product)
                    held_ok = 1'b0;
            end
            if (noisy) begin
                bus.start = 1'b1;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end

        check_output("latency", done_at, p + s + 1);
        check_output("busy_cycles", busy_cnt, p + s);
        check_output("alu_trace", {31'd0, trace_ok && (idx == expq.size())}, 32'd1);
        check_output("product_held", {31'd0, held_ok}, 32'd1);
        check_output("product", bus.product, prod_m);
        check_output("busy_in_done", {31'd0, bus.busy}, 32'd0);
        last_product = prod_m;

        if (chain) begin
            bus.start = 1'b1;
            bus.src_a = na;
            bus.src_b = nb;
        end else begin
            bus.start = 1'b0;
            @(negedge clk);
            check_output("done_pulse", {31'd0, bus.done}, 32'd0);
            check_output("product_after", bus.product, prod_m);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_done", {31'd0, bus.done}, 32'd0);
        check_output("rst_product", bus.product, 32'd0);
        check_output("rst_alu", {bus.alu_op, bus.alu_a[27:0]} | bus.alu_b, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("idle_busy", {31'd0, bus.busy}, 32'd0);

        apply_stimulus(32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(32'd7, 32'd9, 1'b1, 1'b1, 32'd2, 32'h8000_0000);
        apply_stimulus(32'd2, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 32'd0);

        // Abort a multiply partway through with reset.
        bus.start = 1'b1;
        bus.src_a = 32'd100;
        bus.src_b = 32'd100;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort_done", {31'd0, bus.done}, 32'd0);
        check_output("abort_product", bus.product, 32'd0);
        check_output("abort_alu_op", {28'd0, bus.alu_op}, 32'd0);
        reset = 1'b0;
        last_product = 32'd0;
        apply_stimulus(32'd100, 32'd100, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(32'h8000_0000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb = rb >> $urandom_range(0, 31);
            apply_stimulus(ra, rb, (i % 3) == 0, 1'b0, 32'd0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
